// File: rtl/bpu_gshare_if.sv
// Fetch-lookup and execute-training signal bundle for the gshare branch predictor.
// train_vaild_i is a one-cycle qualifier with no ready: the predictor accepts every event it sees.
interface bpu_gshare_if #(
  parameter int PC_WIDTH = 32,
  parameter int IDX_BITS = 6
);
  logic [PC_WIDTH-1:0] F_PC_i;
  logic                F_train_predict_o;
  logic                F_train_vaild_o;
  logic [PC_WIDTH-1:0] F_pred_target_o;
  logic [IDX_BITS-1:0] F_pht_idx_o;

  logic                train_vaild_i;
  logic [PC_WIDTH-1:0] train_PC_i;
  logic                train_cond_i;
  logic                train_taken_i;
  logic                train_predict_i;
  logic [PC_WIDTH-1:0] train_target_i;
  logic [IDX_BITS-1:0] train_pht_idx_i;

  logic [31:0]         mispredict_cnt_o;

  modport master (
    output F_PC_i, train_vaild_i, train_PC_i, train_cond_i, train_taken_i,
           train_predict_i, train_target_i, train_pht_idx_i,
    input  F_train_predict_o, F_train_vaild_o, F_pred_target_o, F_pht_idx_o,
           mispredict_cnt_o
  );

  modport slave (
    input  F_PC_i, train_vaild_i, train_PC_i, train_cond_i, train_taken_i,
           train_predict_i, train_target_i, train_pht_idx_i,
    output F_train_predict_o, F_train_vaild_o, F_pred_target_o, F_pht_idx_o,
           mispredict_cnt_o
  );
endinterface

// File: rtl/bpu_gshare.sv
// Gshare branch predictor: tagged BTB plus PHT of saturating counters indexed by PC xor GHR.
// Lookup is combinational; training from execute updates state on the following clock edge.
module bpu_gshare #(
  parameter int PC_WIDTH = 32,
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 6,
  parameter int CTR_BITS = 2
) (
  input logic         clk_i,
  input logic         rst,
  bpu_gshare_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = PC_WIDTH - IDX_BITS - 2;
  localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic                btb_valid  [ENTRIES];
  logic [TAG_W-1:0]    btb_tag    [ENTRIES];
  logic [PC_WIDTH-1:0] btb_target [ENTRIES];
  logic                btb_uncond [ENTRIES];
  logic [CTR_BITS-1:0] pht        [ENTRIES];
  logic [GW-1:0]       ghr;
  logic [31:0]         mis_cnt;

  logic [IDX_BITS-1:0] f_idx, f_pht_idx, ghr_idx, t_idx;
  logic [TAG_W-1:0]    f_tag, t_tag;
  logic                f_hit;
  logic [CTR_BITS-1:0] pht_cur, pht_next;
  logic [GW:0]         ghr_shift;
  logic [GW-1:0]       ghr_next;
  logic                mispredict;
  logic                unused_pc_bits;

  // Bimodal build has no history: the PHT index collapses onto the BTB index.
  if (GHR_BITS == 0) begin : g_bimodal
    assign ghr_idx = '0;
  end else begin : g_gshare
    assign ghr_idx = IDX_BITS'(ghr);
  end

  assign f_idx     = bus.F_PC_i[IDX_BITS+1:2];
  assign f_tag     = bus.F_PC_i[PC_WIDTH-1:IDX_BITS+2];
  assign f_pht_idx = f_idx ^ ghr_idx;
  assign f_hit     = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

  assign bus.F_train_vaild_o   = f_hit;
  assign bus.F_pht_idx_o       = f_pht_idx;
  assign bus.F_pred_target_o   = f_hit ? btb_target[f_idx] : bus.F_PC_i + PC_WIDTH'(4);
  assign bus.F_train_predict_o = f_hit && (btb_uncond[f_idx] || pht[f_pht_idx][CTR_BITS-1]);
  assign bus.mispredict_cnt_o  = mis_cnt;

  assign t_idx          = bus.train_PC_i[IDX_BITS+1:2];
  assign t_tag          = bus.train_PC_i[PC_WIDTH-1:IDX_BITS+2];
  assign unused_pc_bits = ^bus.train_PC_i[1:0];

  // A taken target mismatch arrives as predict=0 with taken=1, so one compare covers both cases.
  assign mispredict = bus.train_predict_i != bus.train_taken_i;

  assign ghr_shift = {ghr, bus.train_taken_i};
  assign ghr_next  = ghr_shift[GW-1:0];

  always_comb begin
    pht_cur  = pht[bus.train_pht_idx_i];
    pht_next = pht_cur;
    if (bus.train_taken_i) begin
      if (pht_cur != CTR_MAX) pht_next = pht_cur + CTR_BITS'(1);
    end else begin
      if (pht_cur != '0) pht_next = pht_cur - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_uncond[i] <= 1'b0;
        pht[i]        <= CTR_INIT;
      end
      ghr     <= '0;
      mis_cnt <= '0;
    end else if (bus.train_vaild_i) begin
      if (bus.train_taken_i) begin
        btb_valid[t_idx]  <= 1'b1;
        btb_tag[t_idx]    <= t_tag;
        btb_target[t_idx] <= bus.train_target_i;
        btb_uncond[t_idx] <= !bus.train_cond_i;
      end
      if (bus.train_cond_i) begin
        pht[bus.train_pht_idx_i] <= pht_next;
        ghr                      <= ghr_next;
      end
      if (mispredict && (mis_cnt != 32'hFFFF_FFFF)) mis_cnt <= mis_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_bpu_gshare.sv
// Self-checking bench for bpu_gshare: directed scenarios plus a randomized stream
// compared against a table-level model of the BTB, PHT counters, history and miss counter.
module tb_bpu_gshare;
  localparam int PW = 32;
  localparam int IB = 6;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic rst;

  bpu_gshare_if #(.PC_WIDTH(PW), .IDX_BITS(IB)) bus ();

  bpu_gshare #(.PC_WIDTH(PW), .IDX_BITS(IB), .GHR_BITS(6), .CTR_BITS(2)) dut (
    .clk_i(clk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit          m_valid  [N];
  logic [31:0] m_tag    [N];
  logic [31:0] m_target [N];
  bit          m_uncond [N];
  int          m_pht    [N];
  int          m_ghr;
  longint      m_cnt;

  logic        e_hit, e_pred;
  logic [31:0] e_tgt;
  logic [5:0]  e_pidx;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_uncond[i] = 0; m_pht[i] = 1;
    end
    m_ghr = 0;
    m_cnt = 0;
  endtask

  task automatic model_train(input logic [31:0] pc, input bit cond, input bit taken,
                             input bit pred, input logic [31:0] tgt, input int pidx);
    int i;
    i = int'((pc >> 2) % N);
    if (taken) begin
      m_valid[i] = 1; m_tag[i] = pc >> 8; m_target[i] = tgt; m_uncond[i] = !cond;
    end
    if (cond) begin
      if (taken) m_pht[pidx] = (m_pht[pidx] == 3) ? 3 : m_pht[pidx] + 1;
      else       m_pht[pidx] = (m_pht[pidx] == 0) ? 0 : m_pht[pidx] - 1;
      m_ghr = (m_ghr * 2 + int'(taken)) % N;
    end
    if (pred != taken && m_cnt < 64'hFFFF_FFFF) m_cnt++;
  endtask

  function automatic void model_lookup(input logic [31:0] pc, output logic hit, output logic pred,
                                       output logic [31:0] tgt, output logic [5:0] pidx);
    int i, p;
    i    = int'((pc >> 2) % N);
    p    = i ^ m_ghr;
    hit  = m_valid[i] && (m_tag[i] == (pc >> 8));
    pidx = 6'(p);
    tgt  = hit ? m_target[i] : pc + 32'd4;
    pred = hit && (m_uncond[i] || m_pht[p] >= 2);
  endfunction

  // ---------------- drivers ----------------
  task automatic set_train(input logic [31:0] pc, input bit cond, input bit taken,
                           input bit pred, input logic [31:0] tgt, input int pidx);
    bus.train_vaild_i   = 1'b1;
    bus.train_PC_i      = pc;
    bus.train_cond_i    = cond;
    bus.train_taken_i   = taken;
    bus.train_predict_i = pred;
    bus.train_target_i  = tgt;
    bus.train_pht_idx_i = pidx[5:0];
  endtask

  // Called between a falling and a rising edge; returns just after the next falling edge.
  task automatic tick();
    @(posedge clk);
    if (bus.train_vaild_i && !rst)
      model_train(bus.train_PC_i, bus.train_cond_i, bus.train_taken_i, bus.train_predict_i,
                  bus.train_target_i, int'(bus.train_pht_idx_i));
    #1 bus.train_vaild_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic train(input logic [31:0] pc, input bit cond, input bit taken,
                       input bit pred, input logic [31:0] tgt, input int pidx);
    set_train(pc, cond, taken, pred, tgt, pidx);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.F_PC_i = 32'h100;
    bus.train_vaild_i = 1'b0; bus.train_PC_i = '0; bus.train_cond_i = 1'b0;
    bus.train_taken_i = 1'b0; bus.train_predict_i = 1'b0; bus.train_target_i = '0;
    bus.train_pht_idx_i = '0;
    model_reset();
    #1;
    checks++; if (bus.F_train_vaild_o !== 1'b0) begin errors++; $display("FAIL rst_vaild got %b exp 0", bus.F_train_vaild_o); end
    checks++; if (bus.F_train_predict_o !== 1'b0) begin errors++; $display("FAIL rst_predict got %b exp 0", bus.F_train_predict_o); end
    checks++; if (bus.F_pred_target_o !== 32'h104) begin errors++; $display("FAIL rst_target got %h exp 104", bus.F_pred_target_o); end
    checks++; if (bus.mispredict_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus.mispredict_cnt_o); end
    bus.F_PC_i = 32'h0000_0ABC;
    #1;
    checks++; if (bus.F_pht_idx_o !== 6'h2F) begin errors++; $display("FAIL rst_pht_idx got %h exp 2f", bus.F_pht_idx_o); end
    checks++; if (bus.F_pred_target_o !== 32'h0000_0AC0) begin errors++; $display("FAIL rst_target2 got %h exp ac0", bus.F_pred_target_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.F_PC_i = 32'h100;
    #1;
    checks++; if (bus.F_train_vaild_o !== 1'b0) begin errors++; $display("FAIL post_rst_vaild got %b exp 0", bus.F_train_vaild_o); end
    checks++; if (bus.F_pred_target_o !== 32'h104) begin errors++; $display("FAIL post_rst_target got %h exp 104", bus.F_pred_target_o); end
  endtask

  task automatic test_single_cond();
    train(32'h100, 1'b1, 1'b1, 1'b0, 32'h80, 0);
    bus.F_PC_i = 32'h100;
    #1;
    model_lookup(bus.F_PC_i, e_hit, e_pred, e_tgt, e_pidx);
    checks++; if (bus.F_train_vaild_o !== 1'b1) begin errors++; $display("FAIL cond_vaild got %b exp 1", bus.F_train_vaild_o); end
    checks++; if (bus.F_pred_target_o !== 32'h80) begin errors++; $display("FAIL cond_target got %h exp 80", bus.F_pred_target_o); end
    // History is now 1, so this lookup reads PHT[1] rather than the trained PHT[0].
    checks++; if (bus.F_pht_idx_o !== 6'h01) begin errors++; $display("FAIL cond_ghr_idx got %h exp 01", bus.F_pht_idx_o); end
    checks++; if (bus.F_train_predict_o !== e_pred) begin errors++; $display("FAIL cond_predict got %b exp %b", bus.F_train_predict_o, e_pred); end
    checks++; if (bus.mispredict_cnt_o !== 32'd1) begin errors++; $display("FAIL cond_cnt got %0d exp 1", bus.mispredict_cnt_o); end
  endtask

  task automatic test_saturate();
    // PC 0x1d4 has BTB index 0x35; after the stream the history is 0b110000, landing on PHT[5].
    train(32'h1D4, 1'b1, 1'b1, 1'b1, 32'h40, 63);
    for (int k = 0; k < 6; k++) train(32'h1D4, 1'b1, 1'b1, 1'b1, 32'h40, 5);
    for (int k = 0; k < 4; k++) train(32'h1D4, 1'b1, 1'b0, 1'b0, 32'h40, 5);
    bus.F_PC_i = 32'h1D4;
    #1;
    checks++; if (bus.F_pht_idx_o !== 6'h05) begin errors++; $display("FAIL sat_pht_idx got %h exp 05", bus.F_pht_idx_o); end
    checks++; if (bus.F_train_vaild_o !== 1'b1) begin errors++; $display("FAIL sat_vaild got %b exp 1", bus.F_train_vaild_o); end
    checks++; if (bus.F_train_predict_o !== 1'b0) begin errors++; $display("FAIL sat_predict got %b exp 0", bus.F_train_predict_o); end
    checks++; if (bus.F_pred_target_o !== 32'h40) begin errors++; $display("FAIL sat_target got %h exp 40", bus.F_pred_target_o); end
    checks++; if (bus.mispredict_cnt_o !== 32'(m_cnt)) begin errors++; $display("FAIL sat_cnt got %0d exp %0d", bus.mispredict_cnt_o, m_cnt); end
  endtask

  task automatic test_jal();
    int ghr_before;
    ghr_before = m_ghr;
    train(32'h200, 1'b0, 1'b1, 1'b0, 32'h400, 0);
    bus.F_PC_i = 32'h200;
    #1;
    checks++; if (bus.F_train_predict_o !== 1'b1) begin errors++; $display("FAIL jal_predict got %b exp 1", bus.F_train_predict_o); end
    checks++; if (bus.F_pred_target_o !== 32'h400) begin errors++; $display("FAIL jal_target got %h exp 400", bus.F_pred_target_o); end
    checks++; if (bus.F_pht_idx_o !== 6'(ghr_before)) begin errors++; $display("FAIL jal_ghr got %h exp %h", bus.F_pht_idx_o, 6'(ghr_before)); end
    checks++; if (bus.mispredict_cnt_o !== 32'(m_cnt)) begin errors++; $display("FAIL jal_cnt got %0d exp %0d", bus.mispredict_cnt_o, m_cnt); end
  endtask

  task automatic test_alias();
    train(32'h100, 1'b1, 1'b1, 1'b1, 32'h80, 0);
    bus.F_PC_i = 32'h1100;
    #1;
    checks++; if (bus.F_train_vaild_o !== 1'b0) begin errors++; $display("FAIL alias_vaild got %b exp 0", bus.F_train_vaild_o); end
    checks++; if (bus.F_pred_target_o !== 32'h1104) begin errors++; $display("FAIL alias_target got %h exp 1104", bus.F_pred_target_o); end
    bus.F_PC_i = 32'h500;
    set_train(32'h500, 1'b1, 1'b1, 1'b1, 32'h900, 0);
    #1;
    checks++; if (bus.F_train_vaild_o !== 1'b0) begin errors++; $display("FAIL same_cycle_vaild got %b exp 0", bus.F_train_vaild_o); end
    checks++; if (bus.F_pred_target_o !== 32'h504) begin errors++; $display("FAIL same_cycle_target got %h exp 504", bus.F_pred_target_o); end
    tick();
    #1;
    checks++; if (bus.F_pred_target_o !== 32'h900) begin errors++; $display("FAIL after_edge_target got %h exp 900", bus.F_pred_target_o); end
    train(32'h500, 1'b1, 1'b0, 1'b0, 32'h123, 0);
    #1;
    checks++; if (bus.F_train_vaild_o !== 1'b1) begin errors++; $display("FAIL nt_keep_vaild got %b exp 1", bus.F_train_vaild_o); end
    checks++; if (bus.F_pred_target_o !== 32'h900) begin errors++; $display("FAIL nt_keep_target got %h exp 900", bus.F_pred_target_o); end
  endtask

  task automatic test_back_to_back();
    train(32'h600, 1'b1, 1'b1, 1'b0, 32'hA00, 7);
    train(32'h600, 1'b1, 1'b1, 1'b0, 32'hB00, 7);
    bus.F_PC_i = 32'h600;
    #1;
    model_lookup(bus.F_PC_i, e_hit, e_pred, e_tgt, e_pidx);
    checks++; if (bus.F_pred_target_o !== 32'hB00) begin errors++; $display("FAIL b2b_target got %h exp b00", bus.F_pred_target_o); end
    checks++; if (bus.F_train_predict_o !== e_pred) begin errors++; $display("FAIL b2b_predict got %b exp %b", bus.F_train_predict_o, e_pred); end
    checks++; if (bus.F_pht_idx_o !== e_pidx) begin errors++; $display("FAIL b2b_pht_idx got %h exp %h", bus.F_pht_idx_o, e_pidx); end
    checks++; if (bus.mispredict_cnt_o !== 32'(m_cnt)) begin errors++; $display("FAIL b2b_cnt got %0d exp %0d", bus.mispredict_cnt_o, m_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] tpc;
    logic        th, tp;
    logic [31:0] tt;
    logic [5:0]  tidx;
    for (int c = 0; c < 600; c++) begin
      bus.F_PC_i = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 9) < 6) begin
        tpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
        model_lookup(tpc, th, tp, tt, tidx);
        if ($urandom_range(0, 3) == 0) tidx = 6'($urandom_range(0, 63));
        set_train(tpc, $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 255) << 2, int'(tidx));
      end
      #1;
      model_lookup(bus.F_PC_i, e_hit, e_pred, e_tgt, e_pidx);
      checks++; if (bus.F_train_vaild_o !== e_hit) begin errors++; $display("FAIL rnd_vaild pc=%h got %b exp %b", bus.F_PC_i, bus.F_train_vaild_o, e_hit); end
      checks++; if (bus.F_train_predict_o !== e_pred) begin errors++; $display("FAIL rnd_predict pc=%h got %b exp %b", bus.F_PC_i, bus.F_train_predict_o, e_pred); end
      checks++; if (bus.F_pred_target_o !== e_tgt) begin errors++; $display("FAIL rnd_target pc=%h got %h exp %h", bus.F_PC_i, bus.F_pred_target_o, e_tgt); end
      checks++; if (bus.F_pht_idx_o !== e_pidx) begin errors++; $display("FAIL rnd_pht_idx pc=%h got %h exp %h", bus.F_PC_i, bus.F_pht_idx_o, e_pidx); end
      checks++; if (bus.mispredict_cnt_o !== 32'(m_cnt)) begin errors++; $display("FAIL rnd_cnt got %0d exp %0d", bus.mispredict_cnt_o, m_cnt); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    train(32'h300, 1'b1, 1'b1, 1'b0, 32'h700, 0);
    train(32'h300, 1'b1, 1'b1, 1'b0, 32'h700, 1);
    bus.F_PC_i = 32'h300;
    set_train(32'h300, 1'b1, 1'b1, 1'b0, 32'h800, 2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (bus.F_train_vaild_o !== 1'b0) begin errors++; $display("FAIL mid_rst_vaild got %b exp 0", bus.F_train_vaild_o); end
    checks++; if (bus.F_train_predict_o !== 1'b0) begin errors++; $display("FAIL mid_rst_predict got %b exp 0", bus.F_train_predict_o); end
    checks++; if (bus.F_pred_target_o !== 32'h304) begin errors++; $display("FAIL mid_rst_target got %h exp 304", bus.F_pred_target_o); end
    checks++; if (bus.F_pht_idx_o !== 6'h00) begin errors++; $display("FAIL mid_rst_pht_idx got %h exp 00", bus.F_pht_idx_o); end
    checks++; if (bus.mispredict_cnt_o !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d exp 0", bus.mispredict_cnt_o); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.F_train_vaild_o !== 1'b0) begin errors++; $display("FAIL rst_discard_vaild got %b exp 0", bus.F_train_vaild_o); end
    checks++; if (bus.mispredict_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_discard_cnt got %0d exp 0", bus.mispredict_cnt_o); end
    bus.F_PC_i = 32'h100;
    #1;
    checks++; if (bus.F_train_vaild_o !== 1'b0) begin errors++; $display("FAIL rerun_vaild got %b exp 0", bus.F_train_vaild_o); end
    checks++; if (bus.F_train_predict_o !== 1'b0) begin errors++; $display("FAIL rerun_predict got %b exp 0", bus.F_train_predict_o); end
    checks++; if (bus.F_pred_target_o !== 32'h104) begin errors++; $display("FAIL rerun_target got %h exp 104", bus.F_pred_target_o); end
    checks++; if (bus.F_pht_idx_o !== 6'h00) begin errors++; $display("FAIL rerun_pht_idx got %h exp 00", bus.F_pht_idx_o); end
  endtask

  initial begin
    test_reset();
    test_single_cond();
    test_saturate();
    test_jal();
    test_alias();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
